// File: rtl/uart_pkg.sv
// Shared types and constants for the UART result transmitter.
// UART_TX_PARITY_EN selects 8E1 framing; otherwise 8N1.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } tx_state_t;

    localparam logic [7:0] DEF_HDR_INFER = 8'hA5;
    localparam logic [7:0] DEF_HDR_TRAIN = 8'h5A;

    localparam int unsigned UART_DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned UART_BITS_PER_BYTE = 11;
`else
    localparam int unsigned UART_BITS_PER_BYTE = 10;
`endif

    // Two-byte result packet, header sent first.
    typedef struct packed {
        logic [7:0] hdr;
        logic [7:0] label;
    } pkt_t;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_baud_gen.sv
// Bit-period counter: bit_tick_c marks the last cycle of each UART bit.
// Holding clear_i keeps the counter at zero so a new bit starts aligned.
module uart_tx_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic bit_tick_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_tick_c = !clear_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || bit_tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_result_tx.sv
// Frames one result as {header, label} and shifts it out on the UART TX line.
// Define UART_TX_PARITY_EN for an even-parity bit per byte (8E1); default is 8N1.
module uart_result_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  HDR_INFER    = DEF_HDR_INFER,
    parameter logic [7:0]  HDR_TRAIN    = DEF_HDR_TRAIN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    output logic       res_ready,
    input  logic       res_train,
    input  logic [7:0] res_label,
    output logic       tx,
    output logic       busy,
    output logic       pkt_done
);

    tx_state_t  state_q, state_d;
    pkt_t       pkt_q, pkt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       byte_idx_q, byte_idx_d;
    logic       tx_q, tx_d;
    logic       res_ready_q, res_ready_d;
    logic       busy_q, busy_d;
    logic       pkt_done_q, pkt_done_d;

    logic       bit_tick_c;
    logic       baud_clear_c;
    logic [7:0] cur_byte_c;

    uart_tx_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (baud_clear_c),
        .bit_tick_c(bit_tick_c)
    );

    // Next-state and registered-output logic; tx is derived from the next state.
    always_comb begin
        state_d      = state_q;
        pkt_d        = pkt_q;
        bit_idx_d    = bit_idx_q;
        byte_idx_d   = byte_idx_q;
        baud_clear_c = (state_q == IDLE) || (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (res_valid && res_ready_q) begin
                    pkt_d.hdr   = res_train ? HDR_TRAIN : HDR_INFER;
                    pkt_d.label = res_label;
                    bit_idx_d   = '0;
                    byte_idx_d  = 1'b0;
                    state_d     = START;
                end
            end
            START: begin
                if (bit_tick_c) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick_c) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
                        bit_idx_d = '0;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick_c) begin
                    state_d   = STOP;
                    bit_idx_d = '0;
                end
            end
            STOP: begin
                if (bit_tick_c) begin
                    if (!byte_idx_q) begin
                        state_d    = START;
                        byte_idx_d = 1'b1;
                    end else begin
                        state_d    = DONE;
                        byte_idx_d = 1'b0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cur_byte_c = byte_idx_d ? pkt_d.label : pkt_d.hdr;

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = cur_byte_c[bit_idx_d];
            PARITY:  tx_d = even_parity(cur_byte_c);
            default: tx_d = 1'b1;
        endcase

        res_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        pkt_done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pkt_q       <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= 1'b0;
            tx_q        <= 1'b1;
            res_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            pkt_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_q       <= pkt_d;
            bit_idx_q   <= bit_idx_d;
            byte_idx_q  <= byte_idx_d;
            tx_q        <= tx_d;
            res_ready_q <= res_ready_d;
            busy_q      <= busy_d;
            pkt_done_q  <= pkt_done_d;
        end
    end

    assign tx        = tx_q;
    assign res_ready = res_ready_q;
    assign busy      = busy_q;
    assign pkt_done  = pkt_done_q;

endmodule

// File: tb/tb_uart_result_tx.sv
// Bench for uart_result_tx: a line monitor decodes UART bytes and checks them against
// a queue of expected bytes filled by the stimulus; packet timing is checked inline.
module tb_uart_result_tx;

    localparam int unsigned CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PKT_LEN = 88;
    localparam bit PAR     = 1'b1;
`else
    localparam int PKT_LEN = 80;
    localparam bit PAR     = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_train = 1'b0;
    logic [7:0] res_label = 8'h00;
    logic       res_ready;
    logic       tx;
    logic       busy;
    logic       pkt_done;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb_q[$];

    uart_result_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_train(res_train),
        .res_label(res_label),
        .tx       (tx),
        .busy     (busy),
        .pkt_done (pkt_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits n falling edges; gives up early once a reset has been seen.
    task automatic wait_bits(input int n, inout bit ab);
        for (int k = 0; k < n; k++) begin
            if (ab) return;
            @(negedge clk);
            if (!rst) ab = 1'b1;
        end
    endtask

    // Line monitor: samples each bit in its middle and scores the decoded byte.
    initial begin : monitor
        logic [7:0] b;
        logic [7:0] e;
        logic       pb, st, sm;
        bit         ab;
        forever begin
            @(negedge clk);
            if (rst && tx === 1'b0) begin
                ab = 1'b0;
                pb = 1'b0;
                wait_bits(2, ab);
                sm = tx;
                for (int i = 0; i < 8; i++) begin
                    wait_bits(4, ab);
                    b[i] = tx;
                end
                if (PAR) begin
                    wait_bits(4, ab);
                    pb = tx;
                end
                wait_bits(4, ab);
                st = tx;
                if (!ab) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL sb_unexpected: got byte %0h expected none", b);
                    end else begin
                        e = sb_q.pop_front();
                        check("start_bit", 32'(sm), 32'h0);
                        check("data_byte", 32'(b), 32'(e));
                        if (PAR) check("parity_bit", 32'(pb), 32'(^e));
                        check("stop_bit", 32'(st), 32'h1);
                    end
                end
            end
        end
    end

    // Issues one result (called at a falling edge) and checks packet timing.
    task automatic send(input logic tr, input logic [7:0] lb, input bit hold);
        int n;
        bit rdy_hi, busy_lo;
        res_valid = 1'b1;
        res_train = tr;
        res_label = lb;
        sb_q.push_back(tr ? 8'h5A : 8'hA5);
        sb_q.push_back(lb);
        n = 0;
        while (res_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(res_ready), 32'h1);
        @(negedge clk);
        if (!hold) res_valid = 1'b0;
        check("start_latency", 32'(tx), 32'h0);
        n = 0;
        rdy_hi = 1'b0;
        busy_lo = 1'b0;
        while (pkt_done !== 1'b1 && n < 1000) begin
            if (res_ready !== 1'b0) rdy_hi = 1'b1;
            if (busy !== 1'b1) busy_lo = 1'b1;
            @(negedge clk);
            n++;
        end
        check("pkt_len", 32'(n), 32'(PKT_LEN));
        check("ready_low_in_pkt", 32'(rdy_hi), 32'h0);
        check("busy_in_pkt", 32'(busy_lo), 32'h0);
        @(negedge clk);
        check("pkt_done_single", 32'(pkt_done), 32'h0);
        check("ready_in_idle", 32'(res_ready), 32'h1);
        check("busy_in_idle", 32'(busy), 32'h0);
        check("tx_in_idle", 32'(tx), 32'h1);
    endtask

    initial begin : stim
        int n;
        bit seen;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_ready", 32'(res_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_pkt_done", 32'(pkt_done), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(res_ready), 32'h1);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || res_ready !== 1'b1) seen = 1'b1;
        end
        check("idle_quiet", 32'(seen), 32'h0);

        send(1'b0, 8'h07, 1'b0);
        send(1'b1, 8'h03, 1'b0);

        // Valid held across two results: packets run back to back.
        send(1'b0, 8'h01, 1'b1);
        send(1'b0, 8'h02, 1'b0);

        // Valid already dropped: the block must stay idle.
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) seen = 1'b1;
        end
        check("no_reaccept", 32'(seen), 32'h0);

        // Reset during a label data bit aborts the packet.
        res_valid = 1'b1;
        res_train = 1'b0;
        res_label = 8'h96;
        sb_q.push_back(8'hA5);
        n = 0;
        while (res_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        res_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'h1);
        rst = 1'b0;
        #1;
        check("abort_tx", 32'(tx), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_ready", 32'(res_ready), 32'h0);
        repeat (2) @(negedge clk);
        check("abort_sb_header_seen", 32'(sb_q.size()), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_abort", 32'(res_ready), 32'h1);

        send(1'b1, 8'hC3, 1'b0);
        send(1'b0, 8'hFF, 1'b0);
        send(1'b1, 8'h80, 1'b0);

        repeat (60) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
